// File: rtl/f3_move_ctrl.sv
// Game sequencer for the f3 offset RAM: clear, LFSR scramble, then paced player moves
// with a solved check after each one. Sole driver of every ram_* strobe and field.
module f3_move_ctrl #(
    parameter int unsigned SCRAMBLE_MOVES = 64,
    parameter int unsigned MOVE_GAP       = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        sysclk,
    input  logic        sysrst_n,
    input  logic        new_game,
    input  logic        player_req,
    input  logic [3:0]  player_pos,
    input  logic        player_horizontal,
    input  logic        player_increase,
    output logic        player_ack,
    input  logic        ram_offset_all_zero,
    output logic        ram_write,
    output logic [3:0]  ram_write_pos,
    output logic        ram_write_horizontal,
    output logic        ram_write_increase,
    output logic        ram_reset,
    output logic        busy,
    output logic        solved,
    output logic [15:0] move_count
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StScramble,
        StScheck,
        StPlay,
        StPcheck,
        StSolved
    } state_e;

    localparam logic [15:0] ScrambleLoad = 16'(SCRAMBLE_MOVES);
    localparam logic [15:0] GapLoad      = 16'(MOVE_GAP - 1);

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] gap_q;
    logic [15:0] scr_left_q;
    logic [1:0]  chk_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    assign busy   = (state_q == StClear) || (state_q == StSettle) ||
                    (state_q == StScramble) || (state_q == StScheck);
    assign solved = (state_q == StSolved);

    // Write strobes and fields are registered: a decision taken at an edge is the write
    // seen by the RAM during the following cycle.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q              <= StIdle;
            lfsr_q               <= LFSR_SEED;
            gap_q                <= 16'd0;
            scr_left_q           <= 16'd0;
            chk_q                <= 2'd0;
            move_count           <= 16'd0;
            player_ack           <= 1'b0;
            ram_write            <= 1'b0;
            ram_write_pos        <= 4'd0;
            ram_write_horizontal <= 1'b0;
            ram_write_increase   <= 1'b0;
            ram_reset            <= 1'b0;
        end else begin
            lfsr_q               <= {lfsr_q[14:0], lfsr_fb};
            player_ack           <= 1'b0;
            ram_write            <= 1'b0;
            ram_write_pos        <= 4'd0;
            ram_write_horizontal <= 1'b0;
            ram_write_increase   <= 1'b0;
            ram_reset            <= 1'b0;
            if (gap_q != 16'd0) begin
                gap_q <= gap_q - 16'd1;
            end

            if (new_game) begin
                state_q    <= StClear;
                ram_reset  <= 1'b1;
                move_count <= 16'd0;
                scr_left_q <= ScrambleLoad;
            end else begin
                case (state_q)
                    StIdle: ;
                    StClear: state_q <= StSettle;
                    // The first scramble write is decided as SETTLE ends so it lands right
                    // after the single quiet cycle.
                    StSettle, StScramble: begin
                        state_q <= StScramble;
                        if (gap_q == 16'd0) begin
                            ram_write            <= 1'b1;
                            ram_write_pos        <= lfsr_q[3:0];
                            ram_write_horizontal <= lfsr_q[4];
                            ram_write_increase   <= lfsr_q[5];
                            gap_q                <= GapLoad;
                            scr_left_q           <= scr_left_q - 16'd1;
                            if (scr_left_q == 16'd1) begin
                                state_q <= StScheck;
                                chk_q   <= 2'd2;
                            end
                        end
                    end
                    StScheck: begin
                        if (chk_q != 2'd0) begin
                            chk_q <= chk_q - 2'd1;
                        end else if (ram_offset_all_zero) begin
                            scr_left_q <= ScrambleLoad;
                            state_q    <= StScramble;
                        end else begin
                            state_q <= StPlay;
                        end
                    end
                    StPlay: begin
                        if (player_req && gap_q == 16'd0) begin
                            player_ack           <= 1'b1;
                            ram_write            <= 1'b1;
                            ram_write_pos        <= player_pos;
                            ram_write_horizontal <= player_horizontal;
                            ram_write_increase   <= player_increase;
                            gap_q                <= GapLoad;
                            if (move_count != 16'hFFFF) begin
                                move_count <= move_count + 16'd1;
                            end
                            chk_q   <= 2'd2;
                            state_q <= StPcheck;
                        end
                    end
                    StPcheck: begin
                        if (chk_q != 2'd0) begin
                            chk_q <= chk_q - 2'd1;
                        end else begin
                            state_q <= ram_offset_all_zero ? StSolved : StPlay;
                        end
                    end
                    StSolved: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f3_move_ctrl.sv
// Bench for f3_move_ctrl: cycle-level reference model compared every cycle, plus
// directed scenarios with hand-derived expectations and a randomized soak.
module tb_f3_move_ctrl;

    localparam int MOVES = 64;
    localparam int GAP   = 4;

    localparam int PH_IDLE     = 0;
    localparam int PH_CLEAR    = 1;
    localparam int PH_SETTLE   = 2;
    localparam int PH_SCRAMBLE = 3;
    localparam int PH_SCHECK   = 4;
    localparam int PH_PLAY     = 5;
    localparam int PH_PCHECK   = 6;
    localparam int PH_SOLVED   = 7;

    logic        sysclk = 1'b0;
    logic        sysrst_n = 1'b1;
    logic        new_game = 1'b0;
    logic        player_req = 1'b0;
    logic [3:0]  player_pos = 4'd0;
    logic        player_horizontal = 1'b0;
    logic        player_increase = 1'b0;
    logic        player_ack;
    logic        ram_offset_all_zero = 1'b0;
    logic        ram_write;
    logic [3:0]  ram_write_pos;
    logic        ram_write_horizontal;
    logic        ram_write_increase;
    logic        ram_reset;
    logic        busy;
    logic        solved;
    logic [15:0] move_count;

    always #5 sysclk = ~sysclk;

    f3_move_ctrl #(
        .SCRAMBLE_MOVES(MOVES),
        .MOVE_GAP      (GAP),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .sysclk              (sysclk),
        .sysrst_n            (sysrst_n),
        .new_game            (new_game),
        .player_req          (player_req),
        .player_pos          (player_pos),
        .player_horizontal   (player_horizontal),
        .player_increase     (player_increase),
        .player_ack          (player_ack),
        .ram_offset_all_zero (ram_offset_all_zero),
        .ram_write           (ram_write),
        .ram_write_pos       (ram_write_pos),
        .ram_write_horizontal(ram_write_horizontal),
        .ram_write_increase  (ram_write_increase),
        .ram_reset           (ram_reset),
        .busy                (busy),
        .solved              (solved),
        .move_count          (move_count)
    );

    int errors = 0;
    int checks = 0;
    int req_mode = 0;  // 0 none, 1 random requester, 2 fixed pos=3/h=1/inc=1

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: timestamps of write decisions instead of a down-counter.
    int          m_phase;
    int          m_edge;
    int          m_last_dec;
    int          m_sample_at;
    int          m_left;
    logic [15:0] m_lfsr;
    logic [15:0] m_mc;
    logic        e_wr, e_h, e_inc, e_ack, e_rst;
    logic [3:0]  e_pos;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        int   taps[4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ v[taps[i] - 1];
        return {v[14:0], fb};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_edge = 0;
        m_last_dec = -1000;
        m_sample_at = -1;
        m_left = 0;
        m_lfsr = 16'hACE1;
        m_mc = 16'd0;
        {e_wr, e_pos, e_h, e_inc, e_ack, e_rst} = '0;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        bit          can_wr;
        cur = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        m_edge++;
        can_wr = (m_edge - m_last_dec) >= GAP;
        {e_wr, e_pos, e_h, e_inc, e_ack, e_rst} = '0;
        if (new_game) begin
            m_phase = PH_CLEAR;
            e_rst = 1'b1;
            m_mc = 16'd0;
            m_left = MOVES;
        end else begin
            case (m_phase)
                PH_CLEAR: m_phase = PH_SETTLE;
                PH_SETTLE, PH_SCRAMBLE: begin
                    m_phase = PH_SCRAMBLE;
                    if (can_wr) begin
                        e_wr = 1'b1;
                        e_pos = cur[3:0];
                        e_h = cur[4];
                        e_inc = cur[5];
                        m_last_dec = m_edge;
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_SCHECK;
                            m_sample_at = m_edge + 3;
                        end
                    end
                end
                PH_SCHECK: if (m_edge == m_sample_at) begin
                    if (ram_offset_all_zero) begin
                        m_left = MOVES;
                        m_phase = PH_SCRAMBLE;
                    end else begin
                        m_phase = PH_PLAY;
                    end
                end
                PH_PLAY: if (player_req && can_wr) begin
                    e_wr = 1'b1;
                    e_ack = 1'b1;
                    e_pos = player_pos;
                    e_h = player_horizontal;
                    e_inc = player_increase;
                    m_last_dec = m_edge;
                    if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
                    m_phase = PH_PCHECK;
                    m_sample_at = m_edge + 3;
                end
                PH_PCHECK: if (m_edge == m_sample_at) begin
                    m_phase = ram_offset_all_zero ? PH_SOLVED : PH_PLAY;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sysclk or negedge sysrst_n);
            if (!sysrst_n) model_reset();
            else model_step();
        end
    end

    function automatic logic [26:0] dut_outs();
        return {ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase,
                player_ack, ram_reset, busy, solved, move_count};
    endfunction

    function automatic logic [26:0] model_outs();
        logic b, s;
        b = (m_phase >= PH_CLEAR) && (m_phase <= PH_SCHECK);
        s = (m_phase == PH_SOLVED);
        return {e_wr, e_pos, e_h, e_inc, e_ack, e_rst, b, s, m_mc};
    endfunction

    initial begin
        forever begin
            @(negedge sysclk);
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got 0x%07h, want 0x%07h",
                         $time, dut_outs(), model_outs());
            end
        end
    end

    // Requester: holds a request until it sees the ack, then drops it for a cycle.
    initial begin
        forever begin
            @(negedge sysclk);
            if (req_mode == 0 || player_ack) begin
                player_req = 1'b0;
            end else if (!player_req) begin
                if (req_mode == 2) begin
                    player_req = 1'b1;
                    player_pos = 4'd3;
                    player_horizontal = 1'b1;
                    player_increase = 1'b1;
                end else if ($urandom_range(0, 2) == 0) begin
                    player_req = 1'b1;
                    player_pos = 4'($urandom_range(0, 15));
                    player_horizontal = 1'($urandom_range(0, 1));
                    player_increase = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Counts scramble writes from the current negedge; returns at the cycle after the last.
    task automatic scramble_pass(input string tag);
        int last = -1;
        int n = 0;
        int t = 0;
        int bad = 0;
        while (n < MOVES && t < 2000) begin
            if (ram_write) begin
                if (last >= 0 && t - last != GAP) bad++;
                last = t;
                n++;
            end
            @(negedge sysclk);
            t++;
        end
        check({tag, "_writes"}, 32'(n), 32'(MOVES));
        check({tag, "_spacing"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_ack(input string tag, output int waited);
        waited = 0;
        while (!player_ack && waited < 50) begin
            @(negedge sysclk);
            waited++;
        end
        check({tag, "_seen"}, 32'(player_ack), 32'd1);
    endtask

    initial begin
        int t;
        int n;
        int d;
        #1 sysrst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        check("reset_outputs", 32'(dut_outs()), 32'd0);

        // Fresh game straight out of reset: first write uses LFSR value two steps past seed.
        sysrst_n = 1'b1;
        new_game = 1'b1;
        @(negedge sysclk);
        new_game = 1'b0;
        check("clear_pulse", 32'({ram_reset, ram_write, busy}), 32'({1'b1, 1'b0, 1'b1}));
        @(negedge sysclk);
        check("settle_quiet", 32'({ram_reset, ram_write}), 32'd0);
        @(negedge sysclk);
        check("first_lfsr_write",
              32'({ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase}),
              32'({1'b1, 4'd7, 1'b0, 1'b0}));
        scramble_pass("pass1");
        @(negedge sysclk);
        check("busy_hold", 32'(busy), 32'd1);
        @(negedge sysclk);
        check("busy_fall", 32'(busy), 32'd0);

        // Directed player moves.
        req_mode = 2;
        wait_ack("ack1", t);
        check("ack1_write",
              32'({ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase}),
              32'({1'b1, 4'd3, 1'b1, 1'b1}));
        check("move_count_1", 32'(move_count), 32'd1);
        @(negedge sysclk);
        wait_ack("ack2", d);
        check("ack_spacing_ge4", 32'(d + 1 >= GAP), 32'd1);
        ram_offset_all_zero = 1'b1;
        repeat (3) @(negedge sysclk);
        check("solved_set", 32'({solved, busy, move_count}), 32'({1'b1, 1'b0, 16'd2}));
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sysclk);
            if (player_ack || ram_write) n++;
        end
        check("solved_no_ack", 32'(n), 32'd0);

        // Restart from SOLVED, then a scramble that lands solved forces a second pass.
        req_mode = 0;
        new_game = 1'b1;
        ram_offset_all_zero = 1'b0;
        @(negedge sysclk);
        new_game = 1'b0;
        check("newgame_from_solved", 32'({solved, ram_reset, move_count}),
              32'({1'b0, 1'b1, 16'd0}));
        ram_offset_all_zero = 1'b1;
        scramble_pass("pass2a");
        repeat (2) @(negedge sysclk);
        check("rescramble_busy", 32'({busy, solved}), 32'({1'b1, 1'b0}));
        ram_offset_all_zero = 1'b0;
        scramble_pass("pass2b");
        repeat (2) @(negedge sysclk);
        check("after_rescramble", 32'({busy, solved}), 32'd0);

        // Abort a pass after its 10th write.
        new_game = 1'b1;
        @(negedge sysclk);
        new_game = 1'b0;
        n = 0;
        t = 0;
        while (n < 10 && t < 500) begin
            @(negedge sysclk);
            t++;
            if (ram_write) n++;
        end
        check("abort_reach10", 32'(n), 32'd10);
        new_game = 1'b1;
        @(negedge sysclk);
        new_game = 1'b0;
        check("abort_clear", 32'({ram_write, ram_reset, move_count}),
              32'({1'b0, 1'b1, 16'd0}));
        scramble_pass("pass3");

        // Randomized soak against the model.
        req_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge sysclk);
            new_game = ($urandom_range(0, 499) == 0);
            ram_offset_all_zero = ($urandom_range(0, 11) == 0);
        end
        new_game = 1'b0;
        ram_offset_all_zero = 1'b0;
        req_mode = 0;

        // Asynchronous reset while a write is on the bus.
        @(negedge sysclk);
        new_game = 1'b1;
        @(negedge sysclk);
        new_game = 1'b0;
        t = 0;
        while (!ram_write && t < 100) begin
            @(negedge sysclk);
            t++;
        end
        check("write_before_reset", 32'(ram_write), 32'd1);
        #1 sysrst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(dut_outs()), 32'd0);
        repeat (2) @(negedge sysclk);
        req_mode = 2;
        sysrst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sysclk);
            if (player_ack || ram_write || busy) n++;
        end
        check("idle_ignores_req", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
